// File: rtl/req_upload_serializer.sv
// req_upload_serializer: queues whole request messages (up to DEPTH of them)
// and streams each one flit by flit, flit 0 first, into the ring request FIFO.
// A message may be accepted while an earlier one is still draining.
module req_upload_serializer #(
  parameter int FLIT_W    = 16,
  parameter int MAX_FLITS = 3,
  parameter int DEPTH     = 2,
  parameter int LEN_W     = 2,
  parameter int CNT_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MAX_FLITS*FLIT_W-1:0] flits_in,
  input  logic [LEN_W-1:0]            flits_len,
  input  logic                        v_flits_in,
  output logic                        in_rdy,
  input  logic                        fifo_rdy,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        v_flit_out,
  output logic                        flit_head,
  output logic                        flit_tail,
  output logic                        upload_state,
  output logic [CNT_W-1:0]            msg_cnt
);

  localparam int MSG_W = MAX_FLITS * FLIT_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MSG_W-1:0]  msg_data [DEPTH];
  logic [LEN_W-1:0]  msg_len  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LEN_W-1:0]  sel_cnt;
  logic [LEN_W-1:0]  eff_len;
  logic [LEN_W-1:0]  head_len;
  logic [MSG_W-1:0]  head_msg;
  logic [FLIT_W-1:0] sel_flit;
  logic              not_empty;
  logic              push;
  logic              pop;

  // Pointer advance with wrap from DEPTH-1 back to slot 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_msg  = msg_data[rd_ptr];
  assign head_len  = msg_len[rd_ptr];
  assign not_empty = (msg_cnt != '0);

  // Out-of-range lengths (0 or above MAX_FLITS) are treated as a full message.
  always_comb begin
    eff_len = flits_len;
    if (flits_len == '0 || flits_len > LEN_W'(MAX_FLITS))
      eff_len = LEN_W'(MAX_FLITS);
  end

  // Select flit sel_cnt of the head message; flit 0 sits in the top bits.
  always_comb begin
    sel_flit = '0;
    for (int unsigned k = 0; k < MAX_FLITS; k++) begin
      if (sel_cnt == LEN_W'(k))
        sel_flit = head_msg[(MAX_FLITS - 1 - k) * FLIT_W +: FLIT_W];
    end
  end

  // Handshake and flit markers, all derived from the current queue state.
  always_comb begin
    in_rdy       = (msg_cnt != CNT_W'(DEPTH));
    v_flit_out   = not_empty && fifo_rdy;
    flit_head    = not_empty && (sel_cnt == '0);
    flit_tail    = not_empty && (sel_cnt == head_len - LEN_W'(1));
    flit_out     = not_empty ? sel_flit : '0;
    upload_state = not_empty;
    push         = v_flits_in && in_rdy;
    pop          = v_flit_out && flit_tail;
  end

  // Message queue storage, pointers, flit select counter and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sel_cnt <= '0;
      msg_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        msg_data[i] <= '0;
        msg_len[i]  <= '0;
      end
    end else begin
      if (push) begin
        msg_data[wr_ptr] <= flits_in;
        msg_len[wr_ptr]  <= eff_len;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (v_flit_out) begin
        if (flit_tail) begin
          sel_cnt <= '0;
          rd_ptr  <= ptr_inc(rd_ptr);
        end else begin
          sel_cnt <= sel_cnt + LEN_W'(1);
        end
      end
      case ({push, pop})
        2'b10:   msg_cnt <= msg_cnt + CNT_W'(1);
        2'b01:   msg_cnt <= msg_cnt - CNT_W'(1);
        default: msg_cnt <= msg_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_req_upload_serializer.sv
// Self-checking bench for req_upload_serializer: directed scenarios plus a
// randomized run, each compared every cycle against a queue-based message model.
module tb_req_upload_serializer;

  localparam int FLIT_W    = 16;
  localparam int MAX_FLITS = 3;
  localparam int DEPTH     = 2;
  localparam int LEN_W     = 2;
  localparam int CNT_W     = 2;
  localparam int MW        = MAX_FLITS * FLIT_W;
  localparam int OW        = 5 + CNT_W + FLIT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [MW-1:0]     flits_in = '0;
  logic [LEN_W-1:0]  flits_len = '0;
  logic              v_flits_in = 1'b0;
  logic              in_rdy;
  logic              fifo_rdy = 1'b0;
  logic [FLIT_W-1:0] flit_out;
  logic              v_flit_out;
  logic              flit_head;
  logic              flit_tail;
  logic              upload_state;
  logic [CNT_W-1:0]  msg_cnt;

  int errors = 0;
  int checks = 0;

  req_upload_serializer #(
    .FLIT_W(FLIT_W), .MAX_FLITS(MAX_FLITS), .DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flits_in(flits_in), .flits_len(flits_len),
    .v_flits_in(v_flits_in), .in_rdy(in_rdy), .fifo_rdy(fifo_rdy),
    .flit_out(flit_out), .v_flit_out(v_flit_out), .flit_head(flit_head),
    .flit_tail(flit_tail), .upload_state(upload_state), .msg_cnt(msg_cnt)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {in_rdy, valid, head, tail, busy, count, flit}.
  logic [OW-1:0] obs;
  assign obs = {in_rdy, v_flit_out, flit_head, flit_tail, upload_state, msg_cnt, flit_out};

  // Reference model: list of whole messages plus the index of the next flit to send.
  logic [MW-1:0] mq_data[$];
  int            mq_len[$];
  int            pos = 0;

  function automatic logic [OW-1:0] model_out();
    logic [MW-1:0]     d;
    logic [FLIT_W-1:0] f;
    logic              rdy;
    if (mq_data.size() == 0) return {1'b1, 4'b0, CNT_W'(0), FLIT_W'(0)};
    d   = mq_data[0];
    f   = d[MW - 1 - pos * FLIT_W -: FLIT_W];
    rdy = (mq_data.size() != DEPTH);
    return {rdy, fifo_rdy, (pos == 0), (pos == mq_len[0] - 1), 1'b1,
            CNT_W'(mq_data.size()), f};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_tick(output bit pushed);
    bit can_take;
    int elen;
    pushed = 1'b0;
    if (rst) begin
      mq_data.delete();
      mq_len.delete();
      pos = 0;
      return;
    end
    can_take = (mq_data.size() != DEPTH);
    if (mq_data.size() != 0 && fifo_rdy) begin
      if (pos == mq_len[0] - 1) begin
        void'(mq_data.pop_front());
        void'(mq_len.pop_front());
        pos = 0;
      end else begin
        pos++;
      end
    end
    if (v_flits_in && can_take) begin
      elen = int'(flits_len);
      if (elen < 1 || elen > MAX_FLITS) elen = MAX_FLITS;
      mq_data.push_back(flits_in);
      mq_len.push_back(elen);
      pushed = 1'b1;
    end
  endtask

  task automatic set_in(input bit r, input bit v, input logic [MW-1:0] d,
                        input int len, input bit fr);
    rst        = r;
    v_flits_in = v;
    flits_in   = d;
    flits_len  = LEN_W'(len);
    fifo_rdy   = fr;
  endtask

  task automatic finish_cycle();
    bit p;
    model_tick(p);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] e;
    set_in(1, 0, '0, 0, 1);
    finish_cycle();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, '0, 0, c[0]);
      @(negedge clk);
      e = model_out();
      checks++;
      if (obs !== e) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs, e);
      if (obs !== e) errors++;
      finish_cycle();
    end
  endtask

  task automatic test_single();
    logic [OW-1:0] e;
    for (int c = 0; c < 6; c++) begin
      set_in(0, c == 0, 48'hAAAA_BBBB_CCCC, 3, 1);
      @(negedge clk);
      e = model_out();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single cyc=%0d got=%h exp=%h", c, obs, e);
      end
      // Second flit must be BBBB, neither head nor tail, independent of the model.
      if (c == 2) begin
        checks++;
        if ({v_flit_out, flit_head, flit_tail, flit_out} !== {3'b100, 16'hBBBB}) begin
          errors++;
          $display("FAIL single_mid got=%h exp=%h",
                   {v_flit_out, flit_head, flit_tail, flit_out}, {3'b100, 16'hBBBB});
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] e;
    logic [MW-1:0] d;
    for (int c = 0; c < 10; c++) begin
      d = (c == 0) ? 48'h0101_0202_0303 : (c == 1) ? 48'h0404_0505_0606 : 48'h0707_0808_0909;
      set_in(0, c <= 4, d, (c == 0) ? 3 : (c == 1) ? 1 : 2, 1);
      @(negedge clk);
      e = model_out();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs, e);
      end
      // Queue is full on cycles 2 and 3, so the held third message must be refused.
      if (c == 2 || c == 3) begin
        checks++;
        if (in_rdy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_full cyc=%0d got=%b exp=0", c, in_rdy);
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] e;
    for (int c = 0; c < 12; c++) begin
      set_in(0, c == 0, 48'hDEAD_BEEF_CAFE, 3, !(c >= 2 && c <= 6));
      @(negedge clk);
      e = model_out();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, obs, e);
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if ({v_flit_out, flit_out} !== {1'b0, 16'hBEEF}) begin
          errors++;
          $display("FAIL bp_frozen cyc=%0d got=%h exp=%h", c, {v_flit_out, flit_out},
                   {1'b0, 16'hBEEF});
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_len_clamp();
    logic [OW-1:0] e;
    for (int c = 0; c < 6; c++) begin
      set_in(0, c == 0, 48'h1111_2222_3333, 0, 1);
      @(negedge clk);
      e = model_out();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL len_clamp cyc=%0d got=%h exp=%h", c, obs, e);
      end
      if (c == 3) begin
        checks++;
        if ({v_flit_out, flit_tail, flit_out} !== {2'b11, 16'h3333}) begin
          errors++;
          $display("FAIL clamp_tail got=%h exp=%h", {v_flit_out, flit_tail, flit_out},
                   {2'b11, 16'h3333});
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] e;
    logic [MW-1:0] d;
    for (int c = 0; c < 10; c++) begin
      d = (c == 0) ? 48'hA1A1_A2A2_A3A3 : (c == 1) ? 48'hB1B1_B2B2_B3B3 : 48'hC1C1_C2C2_C3C3;
      set_in(c == 3, (c <= 1) || (c == 6), d, (c == 1) ? 2 : 3, c != 3);
      @(negedge clk);
      e = model_out();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, obs, e);
      end
      if (c == 4 || c == 5) begin
        checks++;
        if ({v_flit_out, msg_cnt} !== {1'b0, CNT_W'(0)}) begin
          errors++;
          $display("FAIL rst_flush cyc=%0d got=%h exp=0", c, {v_flit_out, msg_cnt});
        end
      end
      if (c == 7) begin
        checks++;
        if ({v_flit_out, flit_head, flit_out} !== {2'b11, 16'hC1C1}) begin
          errors++;
          $display("FAIL rst_fresh got=%h exp=%h", {v_flit_out, flit_head, flit_out},
                   {2'b11, 16'hC1C1});
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] e;
    logic [MW-1:0] d = '0;
    int            len = 0;
    bit            pend = 1'b0;
    bit            p;
    for (int c = 0; c < 600; c++) begin
      if (!pend && c < 580 && $urandom_range(0, 3) != 0) begin
        d    = MW'({$urandom(), $urandom()});
        len  = int'($urandom_range(0, 3));
        pend = 1'b1;
      end
      set_in((c < 580) && ($urandom_range(0, 79) == 0), pend, d, len,
             (c >= 580) || ($urandom_range(0, 9) < 7));
      @(negedge clk);
      e = model_out();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, e);
      end
      model_tick(p);
      if (p || rst) pend = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_len_clamp();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_upload_serializer.md
Name: req_upload_serializer

Overview:
- Parametrised request-upload serializer for a ring node.
- Accepts whole request messages of 1..MAX_FLITS flits, each FLIT_W bits, and buffers up to DEPTH messages in an internal message queue.
- Streams each message flit-by-flit, MSB flit first, into the downstream request FIFO under its ready signal, with head and tail markers on each flit.
- Sits between the cache/core request generator and the ring request FIFO. Unlike a single-message uploader, it accepts back-to-back messages while one is still draining.

Parameters:
- FLIT_W, 16, width of one flit in bits.
- MAX_FLITS, 3, maximum flits per message; input message bus is MAX_FLITS*FLIT_W bits.
- DEPTH, 2, number of whole messages buffered (>=1).
- LEN_W, 2, width of the length field; must satisfy 2^LEN_W > MAX_FLITS.
- CNT_W, 2, width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flits_in  in  MAX_FLITS*FLIT_W  message; flit 0 = bits [MAX_FLITS*FLIT_W-1 -: FLIT_W], flit k follows below it.
- flits_len  in  LEN_W  number of valid flits in flits_in.
- v_flits_in  in  1  message valid.
- in_rdy  out  1  queue can accept a message this cycle.
- fifo_rdy  in  1  downstream FIFO can take a flit this cycle.
- flit_out  out  FLIT_W  current flit.
- v_flit_out  out  1  flit_out is transferred this cycle.
- flit_head  out  1  flit_out is flit 0 of its message.
- flit_tail  out  1  flit_out is the last flit of its message.
- upload_state  out  1  1 while any message is queued or draining.
- msg_cnt  out  CNT_W  number of messages currently held.

Behaviour:
- Reset values (rst sampled at a clk edge): queue empty, msg_cnt=0, read/write pointers=0, flit select counter=0, all stored data=0. Combinational outputs are then in_rdy=1, v_flit_out=0, flit_head=0, flit_tail=0, upload_state=0, flit_out=0.
- Reset mid-message: rst overrides all other activity that cycle. Any partially sent message and all queued messages are discarded; no further flits of them are emitted.
- Accept:
  - A push occurs at an edge when v_flits_in && in_rdy.
  - Data and effective length are stored in the write slot; the write pointer advances modulo DEPTH.
  - in_rdy = (msg_cnt != DEPTH), combinational. It does not look at a same-cycle pop, so a full queue refuses input even while its head message finishes.
  - v_flits_in while in_rdy=0 is ignored; the source must hold the message.
- Length rule: effective length = flits_len if 1 <= flits_len <= MAX_FLITS; otherwise (0 or >MAX_FLITS) effective length = MAX_FLITS.
- Emit:
  - v_flit_out = (msg_cnt != 0) && fifo_rdy, combinational, in the same cycle as fifo_rdy.
  - When msg_cnt != 0, flit_out = flit sel_cnt of the head message. When msg_cnt = 0, flit_out = 0.
  - flit_head = (msg_cnt != 0) && sel_cnt==0.
  - flit_tail = (msg_cnt != 0) && sel_cnt==len-1.
  - flit_out, flit_head and flit_tail are stable while fifo_rdy=0 and no reset occurs.
- Counter and pop:
  - On an edge with v_flit_out=1 and not tail: sel_cnt increments.
  - On an edge with v_flit_out=1 and tail: sel_cnt returns to 0, the read pointer advances modulo DEPTH, and the message is popped.
  - A single-flit message has head=tail=1 and is popped after one transfer.
- Latency: a message accepted at edge N into an empty queue can emit flit 0 in the cycle after edge N. There is no same-cycle bypass.
- Throughput: one flit per cycle while fifo_rdy=1. No idle cycle occurs between consecutive messages.
- Occupancy: push only gives +1; pop only gives -1; simultaneous push and pop leaves msg_cnt unchanged. Pointer wrap DEPTH-1 -> 0.
- upload_state = (msg_cnt != 0).

Test Plan:
- Reset, then idle: after rst, check in_rdy=1, v_flit_out=0, flit_out=0, msg_cnt=0, upload_state=0.
- Single 3-flit message with FLIT_W=16, fifo_rdy=1, flits_in=48'hAAAA_BBBB_CCCC, len=3:
  - Expect next cycles AAAA(head), BBBB, CCCC(tail), one per cycle.
  - Then upload_state=0.
- Back-to-back with DEPTH=2:
  - Push messages M1 (len=3) and M2 (len=1) on consecutive edges, fifo_rdy=1.
  - Expect 4 consecutive valid flits, with M2's flit having head=tail=1.
  - A third push attempted while msg_cnt=2 is refused (in_rdy=0) and accepted once msg_cnt drops.
- Backpressure: hold fifo_rdy=0 for 5 cycles mid-message after flit 0.
  - Expect v_flit_out=0 and flit_out frozen at flit 1 throughout, then resume with no loss or duplication.
- Length clamp: push flits_len=0 with 48'h1111_2222_3333.
  - Expect 3 flits 1111, 2222, 3333 with tail on 3333.
- Reset mid-message: assert rst after flit 1 of a 3-flit message with a second message queued.
  - Expect no further valid flits, msg_cnt=0, and a fresh message afterwards starting at its flit 0 with head=1.
